// File: rtl/axi4l_gpio_if.sv
// AXI4-Lite bus bundle between a master (VIP/PS) and the GPIO register slave.
//
// Handshake rule for every channel (AW, W, B, AR, R): the source raises
// valid and holds it and its payload unchanged until it sees ready high
// on a rising clk edge; a transfer occurs on exactly that edge.  The sink
// may raise or drop ready at any time, and ready never depends
// combinationally on valid.
interface axi4l_gpio_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_gpio_slv.sv
// AXI4-Lite GPIO slave: four 32-bit registers decoded from addr[11:2].
//   0x0 GPIO_IN (RO, synchronised), 0x4 EDGE (rising-edge status, W1C),
//   0x8 GPIO_OUT (RW, drives gpio_out), 0xC ID (RO constant).
// Offsets 0x10..0xFFC answer SLVERR with no side effect and rdata 0.
// Independent write and read FSMs; each handles one transaction at a time.
// dbg_state = {write FSM in W_RESP, read FSM in R_RESP}.
module axi4l_gpio_slv #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] OUT_RST  = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE = 32'h4750_494F
) (
    input  logic              clk,
    input  logic              rst,
    axi4l_gpio_if.slave       s_axi,
    input  logic [31:0]       gpio_in,
    output logic [31:0]       gpio_out,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [9:0] IDX_IN   = 10'd0;
    localparam logic [9:0] IDX_EDGE = 10'd1;
    localparam logic [9:0] IDX_OUT  = 10'd2;
    localparam logic [9:0] IDX_ID   = 10'd3;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

    // Expand byte strobes to a bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    // Synchroniser and edge-detect state
    logic [31:0] sync1_q, in_s_q, in_prev_q;
    logic [31:0] edge_sts_q, edge_sts_d;
    logic [31:0] edge_clr;

    // Write side state
    w_state_t    w_state_q, w_state_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        aw_have_q, aw_have_d;
    logic        w_have_q, w_have_d;
    logic [9:0]  aw_idx_q, aw_idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] gpio_out_q, gpio_out_d;
    logic [31:0] wmask;

    // Read side state
    r_state_t    r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rd_word;
    logic [9:0]  ar_idx;

    // Address bits outside [11:2] and the prot fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                           s_axi.awaddr[1:0], s_axi.araddr[1:0],
                           s_axi.awaddr[ADDR_W-1:12], s_axi.araddr[ADDR_W-1:12]};

    assign wmask  = lane_mask(wstrb_q);
    assign ar_idx = s_axi.araddr[11:2];

    // Two-flop synchroniser for gpio_in plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= '0;
            in_s_q    <= '0;
            in_prev_q <= '0;
        end else begin
            sync1_q   <= gpio_in;
            in_s_q    <= sync1_q;
            in_prev_q <= in_s_q;
        end
    end

    // Write FSM next state: capture AW and W independently, update registers
    // the cycle after both are held, then hold the response until accepted.
    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        gpio_out_d = gpio_out_q;
        edge_clr   = '0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.awvalid && awready_q) begin
                    aw_have_d = 1'b1;
                    aw_idx_d  = s_axi.awaddr[11:2];
                    awready_d = 1'b0;
                end else if (!aw_have_q) begin
                    awready_d = 1'b1;
                end
                if (s_axi.wvalid && wready_q) begin
                    w_have_d = 1'b1;
                    wdata_d  = s_axi.wdata;
                    wstrb_d  = s_axi.wstrb;
                    wready_d = 1'b0;
                end else if (!w_have_q) begin
                    wready_d = 1'b1;
                end
                if (aw_have_q && w_have_q) begin
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    bresp_d   = (aw_idx_q > IDX_ID) ? RESP_SLVERR : RESP_OKAY;
                    if (aw_idx_q == IDX_OUT) begin
                        gpio_out_d = (gpio_out_q & ~wmask) | (wdata_q & wmask);
                    end
                    if (aw_idx_q == IDX_EDGE) begin
                        edge_clr = wdata_q & wmask;
                    end
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        // A rising edge seen this cycle overrides a simultaneous clear.
        edge_sts_d = (edge_sts_q & ~edge_clr) | (in_s_q & ~in_prev_q);
    end

    // Write FSM, register file and EDGE status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            gpio_out_q <= OUT_RST;
            edge_sts_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            gpio_out_q <= gpio_out_d;
            edge_sts_q <= edge_sts_d;
        end
    end

    // Read data mux; out-of-map offsets read as zero.
    always_comb begin
        rd_word = '0;
        case (ar_idx)
            IDX_IN:   rd_word = in_s_q;
            IDX_EDGE: rd_word = edge_sts_q;
            IDX_OUT:  rd_word = gpio_out_q;
            IDX_ID:   rd_word = ID_VALUE;
            default:  rd_word = '0;
        endcase
    end

    // Read FSM next state: snapshot data on AR handshake, hold until accepted.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.arvalid && arready_q) begin
                    rdata_d   = rd_word;
                    rresp_d   = (ar_idx > IDX_ID) ? RESP_SLVERR : RESP_OKAY;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_RESP;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_RESP: begin
                if (s_axi.rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign gpio_out      = gpio_out_q;
    assign dbg_state     = {w_state_q == W_RESP, r_state_q == R_RESP};

endmodule

// File: tb/tb_axi4l_gpio_slv.sv
// Self-checking bench for axi4l_gpio_slv: directed register-map, edge, strobe,
// SLVERR and reset sequences, then randomised GPIO_OUT write/read traffic.
module tb_axi4l_gpio_slv;

    localparam logic [31:0] OUT_RST  = 32'h0000_0000;
    localparam logic [31:0] ID_VALUE = 32'h4750_494F;
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    axi4l_gpio_if #(.ADDR_W(32)) axi ();

    axi4l_gpio_slv #(
        .ADDR_W   (32),
        .OUT_RST  (OUT_RST),
        .ID_VALUE (ID_VALUE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axi     (axi),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .dbg_state (dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [33:0] rd_exp_q[$];
    logic [1:0]  wr_exp_q[$];
    logic [31:0] out_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strb_to_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        axi.awaddr  = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata   = '0; axi.wstrb  = '0; axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.araddr  = '0; axi.arprot = '0; axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive AW and W; W leads AW by w_lead cycles. Returns at the negedge
    // after the later of the two handshakes.
    task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int w_lead);
        logic a_f, w_f;
        bit   aw_sent, w_taken;
        @(negedge clk);
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.wvalid  = 1'b1;
        axi.awvalid = (w_lead == 0);
        aw_sent     = (w_lead == 0);
        w_taken     = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            a_f = axi.awvalid && axi.awready;
            w_f = axi.wvalid && axi.wready;
            @(negedge clk);
            if (a_f) axi.awvalid = 1'b0;
            if (w_f) begin axi.wvalid = 1'b0; w_taken = 1'b1; end
            if (w_taken && !aw_sent) begin
                check("wready_low_after_w", 32'(axi.wready), 0);
                check("no_b_without_aw", 32'(axi.bvalid), 0);
            end
            if (!aw_sent && cyc + 1 >= w_lead) begin
                axi.awvalid = 1'b1;
                aw_sent     = 1'b1;
            end
            if (aw_sent && !axi.awvalid && !axi.wvalid) break;
        end
        if (axi.awvalid || axi.wvalid) begin
            check("aw_w_accept_timeout", 0, 1);
            axi.awvalid = 1'b0;
            axi.wvalid  = 1'b0;
        end
    endtask

    task automatic wait_bvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (axi.bvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Pop the expected response and hold bready low for b_delay cycles.
    task automatic finish_write(input int b_delay);
        logic [1:0] exp_resp;
        exp_resp = wr_exp_q.pop_front();
        check("dbg_w_resp", 32'(dbg_state[1]), 1);
        repeat (b_delay) begin
            check("bvalid_hold", 32'(axi.bvalid), 1);
            check("bresp_hold", 32'(axi.bresp), 32'(exp_resp));
            check("awready_busy", 32'(axi.awready), 0);
            check("wready_busy", 32'(axi.wready), 0);
            @(negedge clk);
        end
        axi.bready = 1'b1;
        check("bvalid", 32'(axi.bvalid), 1);
        check("bresp", 32'(axi.bresp), 32'(exp_resp));
        @(negedge clk);
        axi.bready = 1'b0;
        check("bvalid_clear", 32'(axi.bvalid), 0);
        check("awready_back", 32'(axi.awready), 1);
        check("wready_back", 32'(axi.wready), 1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int b_delay);
        logic [1:0]  exp_resp;
        logic [31:0] m;
        bit          ok;
        exp_resp = (addr[11:4] == 8'h00) ? OKAY : SLVERR;
        wr_exp_q.push_back(exp_resp);
        m = strb_to_mask(strb);
        if (addr[11:2] == 10'd2) out_model = (out_model & ~m) | (data & m);
        issue_write(addr, data, strb, w_lead);
        wait_bvalid(ok);
        if (!ok) begin
            check($sformatf("bvalid_timeout@%0h", addr), 0, 1);
            void'(wr_exp_q.pop_front());
        end else begin
            check($sformatf("gpio_out_at_bvalid@%0h", addr), gpio_out, out_model);
            finish_write(b_delay);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int rr_delay);
        logic [33:0] exp;
        bit          got;
        rd_exp_q.push_back({exp_resp, exp_data});
        @(negedge clk);
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (axi.arready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            check($sformatf("arready_timeout@%0h", addr), 0, 1);
            axi.arvalid = 1'b0;
            void'(rd_exp_q.pop_front());
            return;
        end
        @(negedge clk);
        axi.arvalid = 1'b0;
        check("rvalid_latency", 32'(axi.rvalid), 1);
        check("arready_busy", 32'(axi.arready), 0);
        exp = rd_exp_q.pop_front();
        repeat (rr_delay) begin
            check("rvalid_hold", 32'(axi.rvalid), 1);
            check($sformatf("rdata_hold@%0h", addr), axi.rdata, exp[31:0]);
            @(negedge clk);
        end
        axi.rready = 1'b1;
        check($sformatf("rdata@%0h", addr), axi.rdata, exp[31:0]);
        check($sformatf("rresp@%0h", addr), 32'(axi.rresp), 32'(exp[33:32]));
        @(negedge clk);
        axi.rready = 1'b0;
        check("rvalid_clear", 32'(axi.rvalid), 0);
        check("arready_back", 32'(axi.arready), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [3:0]  s;
        bit          ok;

        bus_idle();
        gpio_in   = '0;
        out_model = OUT_RST;
        rst       = 1'b0;
        wait_cycles(3);
        check("rst_awready", 32'(axi.awready), 0);
        check("rst_wready", 32'(axi.wready), 0);
        check("rst_arready", 32'(axi.arready), 0);
        check("rst_bvalid", 32'(axi.bvalid), 0);
        check("rst_rvalid", 32'(axi.rvalid), 0);
        check("rst_rdata", axi.rdata, 0);
        check("rst_gpio_out", gpio_out, OUT_RST);
        check("rst_dbg_state", 32'(dbg_state), 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_awready", 32'(axi.awready), 1);
        check("post_rst_wready", 32'(axi.wready), 1);
        check("post_rst_arready", 32'(axi.arready), 1);

        // GPIO_IN through the synchroniser, ID, and a full EDGE clear.
        gpio_in = 32'h1234_5678;
        wait_cycles(3);
        axi_read(32'h0, 32'h1234_5678, OKAY, 0);
        axi_read(32'hC, ID_VALUE, OKAY, 1);
        axi_read(32'h4, 32'h1234_5678, OKAY, 0);
        axi_write(32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0);
        axi_read(32'h4, 32'h0, OKAY, 0);

        // Falling edges do not set EDGE; a rising edge on bit 0 does.
        gpio_in = 32'h0;
        wait_cycles(4);
        axi_read(32'h4, 32'h0, OKAY, 0);
        gpio_in = 32'h1;
        wait_cycles(4);
        axi_read(32'h4, 32'h1, OKAY, 0);

        // Clear bit 0 while bit 1 rises; then clear bit 2 on the very cycle
        // its rising edge is recorded (the set must survive).
        gpio_in = 32'h3;
        axi_write(32'h4, 32'h1, 4'hF, 0, 0);
        axi_read(32'h4, 32'h2, OKAY, 0);
        gpio_in = 32'h7;
        axi_write(32'h4, 32'h4, 4'hF, 0, 0);
        axi_read(32'h4, 32'h6, OKAY, 0);

        // Clears limited to strobed lanes.
        gpio_in = 32'h207;
        wait_cycles(4);
        axi_read(32'h0, 32'h207, OKAY, 0);
        axi_read(32'h4, 32'h206, OKAY, 0);
        axi_write(32'h4, 32'hFFFF_FFFF, 4'h1, 0, 1);
        axi_read(32'h4, 32'h200, OKAY, 0);
        axi_write(32'h4, 32'hFFFF_FFFF, 4'h2, 0, 0);
        axi_read(32'h4, 32'h0, OKAY, 0);

        // GPIO_OUT byte-lane writes.
        axi_write(32'h8, 32'hA5A5_A5A5, 4'hF, 0, 0);
        check("gpio_out_full", gpio_out, 32'hA5A5_A5A5);
        axi_write(32'h8, 32'hFFFF_FFFF, 4'h2, 0, 0);
        check("gpio_out_lane1", gpio_out, 32'hA5A5_FFA5);
        axi_read(32'h8, 32'hA5A5_FFA5, OKAY, 2);

        // W three cycles ahead of AW, bready held low for five cycles.
        axi_write(32'h8, 32'h0000_1111, 4'hF, 3, 5);
        wait_cycles(3);
        check("single_write_out", gpio_out, 32'h0000_1111);
        check("single_write_bvalid", 32'(axi.bvalid), 0);

        // Out-of-map and read-only offsets, ignored address bits.
        axi_read(32'h10, 32'h0, SLVERR, 0);
        axi_read(32'hFFC, 32'h0, SLVERR, 0);
        axi_write(32'h10, 32'hFFFF_FFFF, 4'hF, 0, 0);
        check("slverr_write_out", gpio_out, 32'h0000_1111);
        axi_write(32'h0, 32'hDEAD_0000, 4'hF, 0, 0);
        axi_write(32'hC, 32'hDEAD_0000, 4'hF, 1, 0);
        axi_read(32'hC, ID_VALUE, OKAY, 0);
        axi_read(32'h4000_0008, 32'h0000_1111, OKAY, 0);
        axi_read(32'h4000_000B, 32'h0000_1111, OKAY, 0);
        axi_write(32'h4000_1009, 32'h2200_0000, 4'h8, 0, 0);
        axi_read(32'h8, 32'h2200_1111, OKAY, 0);

        // Randomised GPIO_OUT traffic.
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(32'h8, d, s, $urandom_range(0, 2), $urandom_range(0, 3));
            axi_read(32'h8, out_model, OKAY, $urandom_range(0, 2));
        end

        // Reset while a write response is waiting for bready.
        gpio_in = 32'h0;
        wait_cycles(4);
        issue_write(32'h8, 32'hDEAD_BEEF, 4'hF, 0);
        wait_bvalid(ok);
        check("rst_mid_bvalid_up", 32'(ok), 1);
        check("rst_mid_out_before", gpio_out, 32'hDEAD_BEEF);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_bvalid", 32'(axi.bvalid), 0);
        check("rst_mid_gpio_out", gpio_out, OUT_RST);
        check("rst_mid_awready", 32'(axi.awready), 0);
        check("rst_mid_wready", 32'(axi.wready), 0);
        check("rst_mid_arready", 32'(axi.arready), 0);
        rst = 1'b1;
        out_model = OUT_RST;
        @(negedge clk);
        check("rst_rel_awready", 32'(axi.awready), 1);
        check("rst_rel_wready", 32'(axi.wready), 1);
        check("rst_rel_arready", 32'(axi.arready), 1);
        axi_read(32'h8, OUT_RST, OKAY, 0);
        axi_read(32'h4, 32'h0, OKAY, 0);
        axi_write(32'h8, 32'h0F0F_0F0F, 4'h5, 0, 0);
        axi_read(32'h8, 32'h000F_000F, OKAY, 0);

        check("wr_queue_drained", 32'(wr_exp_q.size()), 0);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
